// File: rtl/apb_mem_pkg.sv
// Shared types and default constants for the APB memory arbiter slice.
package apb_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam int          DEF_NUM_REQ    = 2;
   localparam int          DEF_ADDR_WIDTH = 32;
   localparam int          DEF_DATA_WIDTH = 32;
   localparam logic [31:0] DEF_ADDR_LIMIT = 32'h0000_1000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr, with wrap.
module rr_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int IW      = 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IW-1:0]      ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IW-1:0]      idx_o
);

   logic          found;
   logic [IW-1:0] cand;
   int            j;

   // Walk the requests starting at ptr; the first hit wins.
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      cand  = '0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = int'(ptr_i) + k;
         if (j >= NUM_REQ) begin
            j = j - NUM_REQ;
         end
         cand = IW'(j);
         if (!found && req_i[cand]) begin
            found       = 1'b1;
            gnt_o[cand] = 1'b1;
            idx_o       = cand;
         end
      end
   end

endmodule

// File: rtl/apb_mem_arbiter.sv
// Shares one memory between NUM_REQ requesters: accept, issue, respond.
//
// state | meaning
// IDLE  | waiting; round-robin accept of one request (req_ready pulse)
// ISSUE | memory access cycle (mem_valid unless the address is illegal)
// RESP  | one-cycle response to the accepted requester, then advance ptr
module apb_mem_arbiter
   import apb_mem_pkg::*;
#(
   parameter int          NUM_REQ    = DEF_NUM_REQ,
   parameter int          ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int          DATA_WIDTH = DEF_DATA_WIDTH,
   parameter logic [31:0] ADDR_LIMIT = DEF_ADDR_LIMIT
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0]            req_wr,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic                          rsp_err,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          mem_valid,
   output logic                          mem_wr_rd,
   output logic [ADDR_WIDTH-1:0]         mem_addr,
   output logic [DATA_WIDTH-1:0]         mem_din,
   input  logic [DATA_WIDTH-1:0]         mem_dout
);

   localparam int IW = $clog2(NUM_REQ);
   // Compare width wide enough for both the address and the 32-bit limit.
   localparam int CW = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

   state_t                  state_q;
   logic [IW-1:0]           ptr_q;
   logic [IW-1:0]           idx_q;
   logic                    wr_q;
   logic                    err_q;
   logic [NUM_REQ-1:0]      rsp_valid_q;
   logic                    rsp_err_q;
   logic                    mem_valid_q;
   logic                    mem_wr_rd_q;
   logic [ADDR_WIDTH-1:0]   mem_addr_q;
   logic [DATA_WIDTH-1:0]   mem_din_q;

   logic [NUM_REQ-1:0]      gnt;
   logic [IW-1:0]           gnt_idx;
   logic [ADDR_WIDTH-1:0]   addr_arr [NUM_REQ];
   logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic                    sel_wr;
   logic                    sel_err;

   for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
      assign addr_arr[g]  = req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign wdata_arr[g] = req_wdata[g*DATA_WIDTH +: DATA_WIDTH];
   end

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IW      (IW)
   ) u_rr (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx)
   );

   assign sel_addr  = addr_arr[gnt_idx];
   assign sel_wdata = wdata_arr[gnt_idx];
   assign sel_wr    = req_wr[gnt_idx];
   assign sel_err   = (CW'(sel_addr) >= CW'(ADDR_LIMIT));

   // Accept is combinational so the requester sees ready in the sampling cycle.
   assign req_ready = (state_q == IDLE && !rst) ? gnt : '0;

   // Memory dout is registered on its side, so it is valid exactly in RESP.
   assign rsp_rdata = (state_q == RESP && !err_q && !wr_q) ? mem_dout : '0;

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign mem_valid = mem_valid_q;
   assign mem_wr_rd = mem_wr_rd_q;
   assign mem_addr  = mem_addr_q;
   assign mem_din   = mem_din_q;

   // Sequencer: latch winner on accept, drive memory for one cycle, respond once.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         wr_q        <= 1'b0;
         err_q       <= 1'b0;
         rsp_valid_q <= '0;
         rsp_err_q   <= 1'b0;
         mem_valid_q <= 1'b0;
         mem_wr_rd_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_din_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               rsp_valid_q <= '0;
               rsp_err_q   <= 1'b0;
               mem_valid_q <= 1'b0;
               if (|req_valid) begin
                  idx_q   <= gnt_idx;
                  wr_q    <= sel_wr;
                  err_q   <= sel_err;
                  state_q <= ISSUE;
                  // Illegal addresses never reach the memory pins.
                  if (!sel_err) begin
                     mem_valid_q <= 1'b1;
                     mem_wr_rd_q <= sel_wr;
                     mem_addr_q  <= sel_addr;
                     mem_din_q   <= sel_wdata;
                  end
               end
            end
            ISSUE: begin
               mem_valid_q <= 1'b0;
               rsp_valid_q <= NUM_REQ'(1) << idx_q;
               rsp_err_q   <= err_q;
               state_q     <= RESP;
            end
            RESP: begin
               rsp_valid_q <= '0;
               rsp_err_q   <= 1'b0;
               ptr_q       <= (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + IW'(1);
               state_q     <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_mem_arbiter.sv
module tb_apb_mem_arbiter;

   localparam int N  = 2;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam logic [31:0] LIMIT = 32'h0000_1000;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_wr;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    rsp_valid;
   logic            rsp_err;
   logic [DW-1:0]   rsp_rdata;
   logic            mem_valid;
   logic            mem_wr_rd;
   logic [AW-1:0]   mem_addr;
   logic [DW-1:0]   mem_din;
   logic [DW-1:0]   mem_dout = '0;

   apb_mem_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .ADDR_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_valid (mem_valid),
      .mem_wr_rd (mem_wr_rd),
      .mem_addr  (mem_addr),
      .mem_din   (mem_din),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // Environment memory: registered read, unwritten words read as all-ones.
   logic [31:0] bmem [logic [31:0]];
   always @(posedge clk) begin
      if (mem_valid) begin
         if (mem_wr_rd) bmem[mem_addr] = mem_din;
         else mem_dout <= bmem.exists(mem_addr) ? bmem[mem_addr] : 32'hFFFF_FFFF;
      end
   end

   // Transaction-level reference model.
   bit          pend [N];
   bit          pwr  [N];
   logic [31:0] paddr[N];
   logic [31:0] pwd  [N];
   logic [31:0] mmem [logic [31:0]];
   int          busy, mptr, widx;
   bit          wwr, werr;
   logic [31:0] waddr, wdat;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] last_rdata;
   logic        last_err;
   logic [N-1:0] obs_ready;
   int          gidx[$];
   int          gcyc[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit anypend();
      bit a = 0;
      for (int i = 0; i < N; i++) a |= pend[i];
      return a;
   endfunction

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         req_valid[i]           = pend[i];
         req_wr[i]              = pwr[i];
         req_addr[i*AW +: AW]   = paddr[i];
         req_wdata[i*DW +: DW]  = pwd[i];
      end
   endtask

   task automatic req(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d);
      pend[i] = 1; pwr[i] = wr; paddr[i] = a; pwd[i] = d;
   endtask

   // One clock: drive at negedge, check mid-cycle, advance model at posedge.
   task automatic step(input bit do_rst);
      int win;
      logic [N-1:0] exp_ready;
      logic [31:0]  exp_rd;
      drive();
      rst = do_rst;
      #1;
      win = -1;
      exp_ready = '0;
      if (busy == 0 && !do_rst) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (mptr + k) % N;
            if (pend[j] && win < 0) win = j;
         end
         if (win >= 0) exp_ready[win] = 1'b1;
      end
      obs_ready = req_ready;
      if (req_ready != '0 && !do_rst) begin
         for (int i = 0; i < N; i++) if (req_ready[i]) gidx.push_back(i);
         gcyc.push_back(cyc);
      end
      if (!do_rst) begin
         chk("req_ready", req_ready, exp_ready);
         chk("mem_valid", mem_valid, (busy == 1 && !werr));
         if (busy == 1 && !werr) begin
            chk("mem_wr_rd", mem_wr_rd, wwr);
            chk("mem_addr", mem_addr, waddr);
            chk("mem_din", mem_din, wdat);
         end
         chk("rsp_valid", rsp_valid, (busy == 2) ? (N'(1) << widx) : '0);
         if (busy == 2) begin
            exp_rd = (werr || wwr) ? 32'h0 :
                     (mmem.exists(waddr) ? mmem[waddr] : 32'hFFFF_FFFF);
            chk("rsp_err", rsp_err, werr);
            chk("rsp_rdata", rsp_rdata, exp_rd);
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
         end
      end
      @(posedge clk);
      cyc++;
      if (busy == 1 && !werr && wwr) mmem[waddr] = wdat;
      if (do_rst) begin
         busy = 0;
         mptr = 0;
      end else begin
         case (busy)
            0: if (win >= 0) begin
               widx = win; wwr = pwr[win]; waddr = paddr[win]; wdat = pwd[win];
               werr = (paddr[win] >= LIMIT);
               pend[win] = 0;
               busy = 1;
            end
            1: busy = 2;
            default: begin
               busy = 0;
               mptr = (widx + 1) % N;
            end
         endcase
      end
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      while ((busy != 0 || anypend()) && n < 60) begin
         step(0);
         n++;
      end
      chk("drain_timeout", (busy != 0 || anypend()), 0);
   endtask

   initial begin
      rst = 1;
      for (int i = 0; i < N; i++) begin
         pend[i] = 0; pwr[i] = 0; paddr[i] = '0; pwd[i] = '0;
      end
      busy = 0; mptr = 0; widx = 0; wwr = 0; werr = 0; waddr = '0; wdat = '0;
      drive();
      step(1);
      step(1);
      chk("rst_req_ready", req_ready, '0);
      chk("rst_rsp_valid", rsp_valid, '0);
      chk("rst_mem_valid", mem_valid, 0);
      chk("rst_mem_addr", mem_addr, '0);

      // Write then read back through requester 0.
      req(0, 1, 32'h10, 32'hDEAD_BEEF);
      drain();
      chk("wr_err", last_err, 0);
      req(0, 0, 32'h10, 32'h0);
      drain();
      chk("rd_data", last_rdata, 32'hDEAD_BEEF);

      // Unwritten location.
      req(1, 0, 32'h20, 32'h0);
      drain();
      chk("unwritten_rd", last_rdata, 32'hFFFF_FFFF);

      // Continuous contention from ptr=0.
      gidx.delete(); gcyc.delete();
      req(0, 0, 32'h10, 0); req(1, 0, 32'h20, 0);
      for (int c = 0; c < 12; c++) begin
         step(0);
         if (!pend[0]) req(0, 0, 32'h10, 0);
         if (!pend[1]) req(1, 0, 32'h20, 0);
      end
      pend[0] = 0; pend[1] = 0;
      drain();
      chk("cont_grants", gidx.size() >= 4, 1);
      if (gidx.size() > 0) chk("cont_first", gidx[0], 0);
      for (int k = 1; k < gidx.size(); k++) begin
         chk("cont_alternate", gidx[k] != gidx[k-1], 1);
         chk("cont_spacing", gcyc[k] - gcyc[k-1], 3);
      end

      // Address errors.
      req(0, 1, 32'h1000, 32'h1234_5678);
      drain();
      chk("err_wr", last_err, 1);
      req(0, 0, 32'h1000, 0);
      drain();
      chk("err_rd", last_err, 1);
      chk("err_rd_data", last_rdata, 32'h0);

      // Reset during ISSUE drops the transaction.
      req(1, 0, 32'h10, 0);
      step(0);
      step(1);
      chk("midrst_req_ready", req_ready, '0);
      chk("midrst_rsp_valid", rsp_valid, '0);
      chk("midrst_rsp_err", rsp_err, 0);
      chk("midrst_rsp_rdata", rsp_rdata, '0);
      chk("midrst_mem_valid", mem_valid, 0);
      chk("midrst_mem_wr_rd", mem_wr_rd, 0);
      chk("midrst_mem_addr", mem_addr, '0);
      chk("midrst_mem_din", mem_din, '0);
      for (int c = 0; c < 3; c++) step(0);
      req(1, 0, 32'h10, 0);
      drain();
      chk("post_rst_rd", last_rdata, 32'hDEAD_BEEF);

      // Late re-request loses to the already-pending requester.
      req(0, 0, 32'h10, 0); req(1, 0, 32'h20, 0);
      step(0); step(0); step(0);
      req(0, 0, 32'h10, 0);
      step(0);
      chk("late_rerequest", obs_ready, 2'b10);
      drain();

      // Randomized traffic against the model.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               logic [31:0] a;
               case ($urandom_range(0, 5))
                  0, 1, 2: a = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
                  3:       a = 32'h0000_0FFC;
                  4:       a = 32'h0000_1000;
                  default: a = $urandom;
               endcase
               req(i, 1'($urandom_range(0, 1)), a, $urandom);
            end else if (pend[i] && $urandom_range(0, 7) == 0) begin
               pwd[i] = $urandom;
            end
         end
         step($urandom_range(0, 99) == 0);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
